// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame streamer.
package oled_pkg;

    localparam int unsigned FRAME_BYTES = 1024;
    localparam int unsigned BC_W        = $clog2(FRAME_BYTES);
    localparam int unsigned CMD_BYTES   = 6;

    typedef enum logic [1:0] {
        ST_RES_HOLD,
        ST_INIT_CMD,
        ST_WINDOW_CMD,
        ST_DATA
    } state_t;

    typedef enum logic [1:0] {
        TX_GAP,
        TX_LOAD,
        TX_SHIFT
    } tx_state_t;

    // Display off, charge pump on, horizontal addressing, display on.
    localparam logic [0:CMD_BYTES-1][7:0] INIT_CMDS =
        {8'hAE, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hAF};

    // Full-screen column/page window, re-sent at the start of every frame.
    localparam logic [0:CMD_BYTES-1][7:0] WINDOW_CMDS =
        {8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    function automatic logic [7:0] cmd_byte(input logic init_sel, input logic [2:0] idx);
        cmd_byte = init_sel ? INIT_CMDS[idx] : WINDOW_CMDS[idx];
    endfunction

endpackage

// File: rtl/oled_frame_streamer_spi_byte_tx.sv
// One SPI mode-0 byte per start: GAP (idle, cs high) -> LOAD -> SHIFT, MSB first.
module spi_byte_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       dc_in,
    output logic       busy,
    output logic       done,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_cs,
    output logic       oled_dc
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             half_end_c;

    assign half_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= TX_GAP;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_GAP:   if (start) state_nxt = TX_LOAD;
            TX_LOAD:  state_nxt = TX_SHIFT;
            TX_SHIFT: if (done) state_nxt = TX_GAP;
            default:  state_nxt = TX_GAP;
        endcase
    end

    // done flags the last SHIFT cycle so the caller can act on the GAP-entry edge.
    always_comb begin
        busy = (state != TX_GAP);
        done = (state == TX_SHIFT) && oled_sclk && half_end_c && (bit_cnt == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            oled_sclk <= 1'b0;
            oled_sdin <= 1'b0;
            oled_cs   <= 1'b1;
            oled_dc   <= 1'b0;
        end else begin
            case (state)
                TX_LOAD: begin
                    shreg     <= byte_in;
                    oled_sdin <= byte_in[7];
                    oled_dc   <= dc_in;
                    oled_cs   <= 1'b0;
                    oled_sclk <= 1'b0;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                end
                TX_SHIFT: begin
                    if (!half_end_c) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else begin
                            oled_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                oled_cs <= 1'b1;
                            end else begin
                                bit_cnt   <= bit_cnt + 3'd1;
                                shreg     <= {shreg[6:0], 1'b0};
                                oled_sdin <= shreg[6];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// Continuous SSD1306 128x64 frame refresh over write-only 4-wire SPI.
// OLED_INIT_SEQ_EN compiles in the panel reset hold and init command sequence.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESET_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      data_to_send,
    output logic [BC_W-1:0] byte_counter,
    output logic            oled_sclk,
    output logic            oled_sdin,
    output logic            oled_cs,
    output logic            oled_dc,
    output logic            oled_res,
    output logic            frame_done
);

    if (CLK_DIV == 0 || RESET_CYCLES == 0) begin : g_param_check
        $error("oled_frame_streamer: CLK_DIV and RESET_CYCLES must be >= 1");
    end

`ifdef OLED_INIT_SEQ_EN
    localparam state_t ST_AFTER_RESET = ST_RES_HOLD;
`else
    localparam state_t ST_AFTER_RESET = ST_WINDOW_CMD;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cmd_idx;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_dc;
    logic       tx_busy;
    logic       tx_done;
    logic       last_cmd_c;
    logic       last_data_c;

    assign last_cmd_c  = (cmd_idx == 3'(CMD_BYTES - 1));
    assign last_data_c = (byte_counter == BC_W'(FRAME_BYTES - 1));

`ifdef OLED_INIT_SEQ_EN
    localparam int unsigned RES_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [RES_CNT_W-1:0] res_cnt;
    logic                 res_done_c;

    assign res_done_c = (res_cnt == RES_CNT_W'(RESET_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            res_cnt  <= '0;
            oled_res <= 1'b0;
        end else if (state == ST_RES_HOLD) begin
            if (res_done_c) oled_res <= 1'b1;
            else            res_cnt  <= res_cnt + RES_CNT_W'(1);
        end
    end
`else
    assign oled_res = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_AFTER_RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef OLED_INIT_SEQ_EN
            ST_RES_HOLD:   if (res_done_c) state_nxt = ST_INIT_CMD;
            ST_INIT_CMD:   if (tx_done && last_cmd_c) state_nxt = ST_WINDOW_CMD;
`endif
            ST_WINDOW_CMD: if (tx_done && last_cmd_c) state_nxt = ST_DATA;
            ST_DATA:       if (tx_done && last_data_c) state_nxt = ST_WINDOW_CMD;
            default:       state_nxt = ST_WINDOW_CMD;
        endcase
    end

    // Next byte is requested while the transmitter idles in GAP, keeping GAP to one cycle.
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = data_to_send;
        tx_dc    = 1'b1;
        case (state)
            ST_INIT_CMD, ST_WINDOW_CMD: begin
                tx_start = !tx_busy;
                tx_byte  = cmd_byte(state == ST_INIT_CMD, cmd_idx);
                tx_dc    = 1'b0;
            end
            ST_DATA:  tx_start = !tx_busy;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_idx      <= '0;
            byte_counter <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tx_done) begin
                case (state)
                    ST_INIT_CMD, ST_WINDOW_CMD:
                        cmd_idx <= last_cmd_c ? 3'd0 : cmd_idx + 3'd1;
                    ST_DATA: begin
                        byte_counter <= last_data_c ? '0 : byte_counter + BC_W'(1);
                        frame_done   <= last_data_c;
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .start     (tx_start),
        .byte_in   (tx_byte),
        .dc_in     (tx_dc),
        .busy      (tx_busy),
        .done      (tx_done),
        .oled_sclk (oled_sclk),
        .oled_sdin (oled_sdin),
        .oled_cs   (oled_cs),
        .oled_dc   (oled_dc)
    );

endmodule
